exc_commit: RTL

Exception commit stage between the MEM pipeline register and the CP0 register file. It accepts one instruction per handshake, prioritises the instruction's exception flags together with the pending-interrupt request from CP0, and presents a single registered one-hot exception vector, PC, delay-slot flag and bad address to CP0. It then flushes the pipeline and drives a fetch redirect, to the exception vector or to EPC for `eret`, through a valid/ready handshake.

---
 rtl/exc_cnt.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/exc_cnt.sv
// exc_commit : exception commit stage between MEM and CP0.
//
// Accepts one instruction per mem_valid/mem_ready handshake, prioritises its
// exception flags together with the CP0 interrupt request, and presents a
// registered one-hot exception vector, PC, delay-slot flag and bad address to
// CP0. It then flushes the pipeline for one cycle and issues a fetch redirect
// (exception vector, or EPC for eret) through a valid/ready handshake.
//
// Optional feature: define EXC_CNT_EN to build a 32-bit taken-exception
// counter on exc_cnt. Without it exc_cnt is tied to zero.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mem_valid / mem_ready     instruction handshake from MEM
//   mem_pc, mem_is_slot       instruction PC and delay-slot flag
//   mem_data_addr             load/store effective address
//   mem_adel_if .. mem_ades   exception flags, mem_eret eret marker
//   int_happen, epc           CP0 interrupt request and saved EPC
//   exc_type, exc_pc,
//   exc_is_slot, bad_vaddr,
//   eret                      commit information to CP0
//   flush                     kill all younger pipeline stages
//   redirect_valid/ready/pc   fetch redirect handshake
//   exc_cnt                   count of taken exceptions
module exc_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_pc,
  input  logic        mem_is_slot,
  input  logic [31:0] mem_data_addr,
  input  logic        mem_adel_if,
  input  logic        mem_ri,
  input  logic        mem_ov,
  input  logic        mem_sys,
  input  logic        mem_bp,
  input  logic        mem_adel_ld,
  input  logic        mem_ades,
  input  logic        mem_eret,
  input  logic        int_happen,
  input  logic [31:0] epc,
  output logic [6:0]  exc_type,
  output logic [31:0] exc_pc,
  output logic        exc_is_slot,
  output logic [31:0] bad_vaddr,
  output logic        eret,
  output logic        flush,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic [31:0] exc_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } state_t;

  state_t      state;
  logic        kind_exc;
  logic [6:0]  nxt_type;
  logic        bva_load;
  logic [31:0] bva_val;
  logic        has_exc;

  // Exception priority encoder. exc_type bit order is
  // {int, adel, ades, sys, bp, ri, ov}. Only address errors update
  // bad_vaddr; everything else leaves the previous value in place.
  always_comb begin
    nxt_type = 7'b0;
    bva_load = 1'b0;
    bva_val  = mem_data_addr;
    if (int_happen) begin
      nxt_type = 7'b1000000;
    end else if (mem_adel_if) begin
      nxt_type = 7'b0100000;
      bva_load = 1'b1;
      bva_val  = mem_pc;
    end else if (mem_ri) begin
      nxt_type = 7'b0000010;
    end else if (mem_ov) begin
      nxt_type = 7'b0000001;
    end else if (mem_sys) begin
      nxt_type = 7'b0001000;
    end else if (mem_bp) begin
      nxt_type = 7'b0000100;
    end else if (mem_adel_ld) begin
      nxt_type = 7'b0100000;
      bva_load = 1'b1;
    end else if (mem_ades) begin
      nxt_type = 7'b0010000;
      bva_load = 1'b1;
    end
  end

  assign has_exc = |nxt_type;

  // Commit FSM. All outputs are registered; mem_ready mirrors state==IDLE.
  // exc_type/eret pulse only in FLUSH, while exc_pc, exc_is_slot and
  // bad_vaddr persist for CP0 until the next exception or eret. epc is
  // sampled in FLUSH (not at accept) so the redirect uses CP0's saved EPC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      kind_exc       <= 1'b0;
      mem_ready      <= 1'b1;
      exc_type       <= 7'b0;
      exc_pc         <= 32'h0;
      exc_is_slot    <= 1'b0;
      bad_vaddr      <= 32'h0;
      eret           <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid && (has_exc || mem_eret)) begin
            state       <= FLUSH;
            mem_ready   <= 1'b0;
            flush       <= 1'b1;
            kind_exc    <= has_exc;
            exc_type    <= nxt_type;
            eret        <= ~has_exc;
            exc_pc      <= mem_pc;
            exc_is_slot <= mem_is_slot;
            if (bva_load) begin
              bad_vaddr <= bva_val;
            end
          end
        end
        FLUSH: begin
          state          <= REDIRECT;
          flush          <= 1'b0;
          exc_type       <= 7'b0;
          eret           <= 1'b0;
          redirect_valid <= 1'b1;
          redirect_pc    <= kind_exc ? EXC_VECTOR : epc;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            mem_ready      <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          mem_ready      <= 1'b1;
          flush          <= 1'b0;
          exc_type       <= 7'b0;
          eret           <= 1'b0;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_CNT_EN
  // Taken-exception counter: one increment per exception FLUSH cycle,
  // eret excluded; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_cnt <= 32'h0;
    end else if (state == FLUSH && kind_exc) begin
      exc_cnt <= exc_cnt + 32'h1;
    end
  end
`else
  assign exc_cnt = 32'h0;
`endif

endmodule
